// File: rtl/barrel_shifter16_pkg.sv
// rtl/barrel_shifter16_pkg.sv - shared widths and op encodings for barrel_shifter16
package barrel_shifter16_pkg;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

endpackage

// File: rtl/barrel_shifter16_stage.sv
// rtl/barrel_shifter16_stage.sv - barrel_stage: one fixed-distance mux layer for all four ops
module barrel_stage
    import barrel_shifter16_pkg::*;
#(
    parameter int DIST = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic             fill,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = d;
        case (op)
            OP_SLL:  shifted = d << DIST;
            OP_SRL:  shifted = d >> DIST;
            // fill comes from the original operand MSB, not this stage's input
            OP_SRA:  shifted = {{DIST{fill}}, d[WIDTH-1:DIST]};
            OP_ROL:  shifted = {d[WIDTH-1-DIST:0], d[WIDTH-1:WIDTH-DIST]};
            default: shifted = d;
        endcase
    end

    assign q = en ? shifted : d;

endmodule

// File: rtl/barrel_shifter16.sv
// rtl/barrel_shifter16.sv - 16-bit registered shifter/rotator; BARREL_ZERO_FLAG_EN adds the zero flag
module barrel_shifter16
    import barrel_shifter16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i0,
    input  logic [SHW-1:0]   s,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] o
`ifdef BARREL_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    logic [WIDTH-1:0] stage_data [0:SHW];

    assign stage_data[0] = i0;

    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : g_stage
            barrel_stage #(
                .DIST(1 << k)
            ) u_stage (
                .d    (stage_data[k]),
                .en   (s[k]),
                .op   (op),
                .fill (i0[WIDTH-1]),
                .q    (stage_data[k+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o <= '0;
        end else begin
            o <= stage_data[SHW];
        end
    end

`ifdef BARREL_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero <= 1'b1;
        end else begin
            zero <= (stage_data[SHW] == '0);
        end
    end
`endif

endmodule

// File: tb/tb_barrel_shifter16.sv
// tb/tb_barrel_shifter16.sv - directed self-checking bench for barrel_shifter16 (BARREL_ZERO_FLAG_EN optional)
module tb_barrel_shifter16;

    logic        clk;
    logic        reset;
    logic [15:0] i0;
    logic [3:0]  s;
    logic [1:0]  op;
    logic [15:0] o;
`ifdef BARREL_ZERO_FLAG_EN
    logic        zero;
`endif

    int tests_run;
    int tests_failed;

    barrel_shifter16 dut (
        .clk   (clk),
        .reset (reset),
        .i0    (i0),
        .s     (s),
        .op    (op),
        .o     (o)
`ifdef BARREL_ZERO_FLAG_EN
        ,
        .zero  (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag, input logic [15:0] exp_o);
`ifdef BARREL_ZERO_FLAG_EN
        check({tag, "_zero"}, {15'b0, zero}, {15'b0, (exp_o == 16'h0000)});
`endif
    endtask

    task automatic vec(input string tag, input logic [15:0] a, input logic [3:0] amt,
                       input logic [1:0] opc, input logic [15:0] exp);
        i0 = a;
        s  = amt;
        op = opc;
        @(posedge clk);
        #1;
        check(tag, o, exp);
        check_zero(tag, exp);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b0;
        i0    = 16'hFFFF;
        s     = 4'd0;
        op    = 2'b00;

        #8;
        check("reset_hold", o, 16'h0000);
        check_zero("reset_hold", 16'h0000);
        #4.5;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", o, 16'hFFFF);

        vec("sll_aa55_1",  16'hAA55, 4'd1,  2'b00, 16'h54AA);
        vec("sll_ffff_2",  16'hFFFF, 4'd2,  2'b00, 16'hFFFC);
        vec("sll_0001_3",  16'h0001, 4'd3,  2'b00, 16'h0008);
        vec("srl_aa55_5",  16'hAA55, 4'd5,  2'b01, 16'h0552);
        vec("srl_ffff_6",  16'hFFFF, 4'd6,  2'b01, 16'h03FF);
        vec("srl_0001_7",  16'h0001, 4'd7,  2'b01, 16'h0000);
        vec("sra_aa55_9",  16'hAA55, 4'd9,  2'b10, 16'hFFD5);
        vec("sra_ffff_10", 16'hFFFF, 4'd10, 2'b10, 16'hFFFF);
        vec("sra_0001_11", 16'h0001, 4'd11, 2'b10, 16'h0000);
        vec("rol_aa55_13", 16'hAA55, 4'd13, 2'b11, 16'hB54A);
        vec("rol_ffff_14", 16'hFFFF, 4'd14, 2'b11, 16'hFFFF);
        vec("rol_0001_15", 16'h0001, 4'd15, 2'b11, 16'h8000);

        vec("sll_s0",      16'hAA55, 4'd0,  2'b00, 16'hAA55);
        vec("srl_s0",      16'hAA55, 4'd0,  2'b01, 16'hAA55);
        vec("sra_s0",      16'hAA55, 4'd0,  2'b10, 16'hAA55);
        vec("rol_s0",      16'hAA55, 4'd0,  2'b11, 16'hAA55);
        vec("sll_s15",     16'hAA55, 4'd15, 2'b00, 16'h8000);
        vec("srl_s15",     16'hAA55, 4'd15, 2'b01, 16'h0001);
        vec("sra_s15",     16'hAA55, 4'd15, 2'b10, 16'hFFFF);
        vec("rol_s15",     16'hAA55, 4'd15, 2'b11, 16'hD52A);
        vec("sra_pos_4",   16'h7FFF, 4'd4,  2'b10, 16'h07FF);
        vec("sra_8000_12", 16'h8000, 4'd12, 2'b10, 16'hFFF8);
        vec("sll_1234_8",  16'h1234, 4'd8,  2'b00, 16'h3400);
        vec("srl_1234_4",  16'h1234, 4'd4,  2'b01, 16'h0123);
        vec("rol_1234_4",  16'h1234, 4'd4,  2'b11, 16'h2341);
        vec("rol_8001_1",  16'h8001, 4'd1,  2'b11, 16'h0003);
        vec("zero_in_sll", 16'h0000, 4'd3,  2'b00, 16'h0000);
        vec("zero_in_rol", 16'h0000, 4'd9,  2'b11, 16'h0000);
        vec("nonzero_rol", 16'h0F00, 4'd8,  2'b11, 16'h000F);

        // asynchronous reset mid-stream must clear o before any clock edge
        i0 = 16'h1234;
        s  = 4'd0;
        op = 2'b00;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", o, 16'h0000);
        check_zero("async_reset", 16'h0000);
        @(posedge clk);
        #1;
        check("reset_held_edge", o, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("resume_after_reset", o, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
